// File: rtl/dense_relu_seq.sv
// Time-multiplexed dense layer: NUMAR_MAC lanes, one input element per cycle, fused shift/ReLU/saturate.
// Busy for G*(D+1) cycles after a start edge; layer_terminat then holds until enable drops.
module dense_relu_seq #(
  parameter int NUMAR_NEURONI      = 10,
  parameter int DIMENSIUNE_INTRARE = 32,
  parameter int LATIME_W           = 8,
  parameter int LATIME_DATE        = 16,
  parameter int NUMAR_MAC          = 2,
  parameter int LATIME_ACC         = 32,
  parameter int SHIFT_IESIRE       = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          relu_mode,
  input  logic signed [LATIME_DATE-1:0] date_intrare [0:DIMENSIUNE_INTRARE-1],
  input  logic signed [LATIME_W-1:0]    weights      [0:NUMAR_NEURONI-1][0:DIMENSIUNE_INTRARE-1],
  input  logic signed [LATIME_W-1:0]    biases       [0:NUMAR_NEURONI-1],
  output logic signed [LATIME_DATE-1:0] iesire_layer [0:NUMAR_NEURONI-1],
  output logic                          busy,
  output logic                          layer_terminat
);

  localparam int G  = NUMAR_NEURONI / NUMAR_MAC;
  localparam int KW = (DIMENSIUNE_INTRARE > 1) ? $clog2(DIMENSIUNE_INTRARE) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int NW = (NUMAR_NEURONI > 1) ? $clog2(NUMAR_NEURONI) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIMENSIUNE_INTRARE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic signed [LATIME_ACC-1:0] SAT_HI =
    {{(LATIME_ACC-LATIME_DATE+1){1'b0}}, {(LATIME_DATE-1){1'b1}}};
  localparam logic signed [LATIME_ACC-1:0] SAT_LO =
    {{(LATIME_ACC-LATIME_DATE+1){1'b1}}, {(LATIME_DATE-1){1'b0}}};

  if (NUMAR_NEURONI % NUMAR_MAC != 0) begin : g_bad_lanes
    $error("NUMAR_NEURONI must be a multiple of NUMAR_MAC");
  end
  if (LATIME_ACC < LATIME_DATE + LATIME_W + $clog2(DIMENSIUNE_INTRARE) + 1) begin : g_bad_acc
    $error("LATIME_ACC too narrow for worst-case dot product");
  end

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                         state_q, state_nx;
  logic signed [LATIME_DATE-1:0]  x_q [0:DIMENSIUNE_INTRARE-1];
  logic                           relu_q;
  logic [GW-1:0]                  g_q, g_nx;
  logic [KW-1:0]                  k_q;
  logic signed [LATIME_ACC-1:0]   acc_q [NUMAR_MAC];
  logic signed [LATIME_ACC-1:0]   prod  [NUMAR_MAC];
  logic signed [LATIME_DATE-1:0]  res   [NUMAR_MAC];
  logic [NW-1:0]                  row    [NUMAR_MAC];
  logic [NW-1:0]                  row_nx [NUMAR_MAC];
  logic signed [LATIME_ACC-1:0]   x_ext, sh;

  function automatic logic signed [LATIME_ACC-1:0] sext_w(input logic signed [LATIME_W-1:0] v);
    return {{(LATIME_ACC-LATIME_W){v[LATIME_W-1]}}, v};
  endfunction

  function automatic logic signed [LATIME_ACC-1:0] sext_d(input logic signed [LATIME_DATE-1:0] v);
    return {{(LATIME_ACC-LATIME_DATE){v[LATIME_DATE-1]}}, v};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (enable) state_nx = MAC;
      MAC:     if (k_q == K_LAST) state_nx = STORE;
      STORE:   state_nx = (g_q == G_LAST) ? DONE : MAC;
      DONE:    if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy           = (state_q == MAC) || (state_q == STORE);
  assign layer_terminat = (state_q == DONE);

  always_comb begin
    g_nx  = (g_q == G_LAST) ? '0 : g_q + 1'b1;
    x_ext = sext_d(x_q[k_q]);
    sh    = '0;
    for (int l = 0; l < NUMAR_MAC; l++) begin
      row[l]    = NW'(int'(g_q) * NUMAR_MAC + l);
      row_nx[l] = NW'(int'(g_nx) * NUMAR_MAC + l);
      prod[l]   = x_ext * sext_w(weights[row[l]][k_q]);
      // Arithmetic shift floors toward -inf; ReLU is applied after the shift.
      sh = acc_q[l] >>> SHIFT_IESIRE;
      if (relu_q && sh[LATIME_ACC-1]) sh = '0;
      if (sh > SAT_HI)      res[l] = SAT_HI[LATIME_DATE-1:0];
      else if (sh < SAT_LO) res[l] = SAT_LO[LATIME_DATE-1:0];
      else                  res[l] = sh[LATIME_DATE-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int l = 0; l < NUMAR_MAC; l++) acc_q[l] <= '0;
      for (int n = 0; n < NUMAR_NEURONI; n++) iesire_layer[n] <= '0;
      for (int d = 0; d < DIMENSIUNE_INTRARE; d++) x_q[d] <= '0;
      relu_q <= 1'b0;
      g_q    <= '0;
      k_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          x_q    <= date_intrare;
          relu_q <= relu_mode;
          g_q    <= '0;
          k_q    <= '0;
          for (int l = 0; l < NUMAR_MAC; l++) acc_q[l] <= sext_w(biases[NW'(l)]);
        end
        MAC: begin
          for (int l = 0; l < NUMAR_MAC; l++) acc_q[l] <= acc_q[l] + prod[l];
          k_q <= k_q + 1'b1;
        end
        STORE: begin
          // On the last group g wraps to 0; the reloaded accumulators are never used.
          for (int l = 0; l < NUMAR_MAC; l++) begin
            iesire_layer[row[l]] <= res[l];
            acc_q[l]             <= sext_w(biases[row_nx[l]]);
          end
          g_q <= g_nx;
          k_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_relu_seq.sv
// Bench for dense_relu_seq: a default-size instance checked every cycle against a timing/arithmetic model,
// plus two small instances (shift 0 and shift 4) checked against hand-computed values.
module tb_dense_relu_seq;
  localparam int N = 10, D = 32, L = 2, WW = 8, DW = 16, G = N / L;
  localparam int SN = 4, SD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                 en_d, relu_d, busy_d, term_d;
  logic signed [DW-1:0] x_d [0:D-1];
  logic signed [WW-1:0] w_d [0:N-1][0:D-1];
  logic signed [WW-1:0] b_d [0:N-1];
  logic signed [DW-1:0] out_d [0:N-1];

  logic                 en_s, relu_s, busy_s, term_s, busy_h, term_h;
  logic signed [DW-1:0] x_s [0:SD-1];
  logic signed [WW-1:0] w_s [0:SN-1][0:SD-1];
  logic signed [WW-1:0] b_s [0:SN-1];
  logic signed [DW-1:0] out_s [0:SN-1];
  logic signed [DW-1:0] out_h [0:SN-1];

  int errors = 0;
  int checks = 0;

  dense_relu_seq dut_d (
    .clock(clk), .reset(rst_n), .enable(en_d), .relu_mode(relu_d), .date_intrare(x_d),
    .weights(w_d), .biases(b_d), .iesire_layer(out_d), .busy(busy_d), .layer_terminat(term_d));

  dense_relu_seq #(.NUMAR_NEURONI(SN), .DIMENSIUNE_INTRARE(SD), .SHIFT_IESIRE(0)) dut_s (
    .clock(clk), .reset(rst_n), .enable(en_s), .relu_mode(relu_s), .date_intrare(x_s),
    .weights(w_s), .biases(b_s), .iesire_layer(out_s), .busy(busy_s), .layer_terminat(term_s));

  dense_relu_seq #(.NUMAR_NEURONI(SN), .DIMENSIUNE_INTRARE(SD), .SHIFT_IESIRE(4)) dut_h (
    .clock(clk), .reset(rst_n), .enable(en_s), .relu_mode(relu_s), .date_intrare(x_s),
    .weights(w_s), .biases(b_s), .iesire_layer(out_h), .busy(busy_h), .layer_terminat(term_h));

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Floor division by 2^shift, optional clamp at zero, then saturation to 16 bits.
  function automatic int requant(input longint acc, input int shift, input bit relu);
    longint p, v;
    p = longint'(1) << shift;
    if (acc >= 0) v = acc / p;
    else          v = -((-acc + p - 1) / p);
    if (relu && v < 0) v = 0;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  // Reference for the default instance: results computed at the start edge, group g published
  // (g+1)*(D+1) edges later, done after the last group until enable is seen low.
  bit     m_live = 1'b0, m_run = 1'b0, m_done = 1'b0;
  int     m_t, m_g;
  longint m_acc;
  int     m_res [N];
  int     m_out [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1'b1; m_run = 1'b0; m_done = 1'b0;
      for (int n = 0; n < N; n++) m_out[n] = 0;
    end else if (m_live) begin
      if (m_done) begin
        if (!en_d) m_done = 1'b0;
      end else if (m_run) begin
        m_t++;
        if (m_t % (D + 1) == 0) begin
          m_g = m_t / (D + 1) - 1;
          for (int l = 0; l < L; l++) m_out[m_g*L+l] = m_res[m_g*L+l];
          if (m_g == G - 1) begin m_run = 1'b0; m_done = 1'b1; end
        end
      end else if (en_d) begin
        m_run = 1'b1; m_t = 0;
        for (int n = 0; n < N; n++) begin
          m_acc = longint'(b_d[n]);
          for (int k = 0; k < D; k++) m_acc += longint'(x_d[k]) * longint'(w_d[n][k]);
          m_res[n] = requant(m_acc, 0, relu_d);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy_d", int'(busy_d), int'(m_run));
      chk("term_d", int'(term_d), int'(m_done));
      checks++;
      for (int n = 0; n < N; n++) begin
        if (int'(out_d[n]) !== m_out[n]) begin
          errors++;
          $display("FAIL out_d[%0d]: got %0d expected %0d (t=%0t)", n, out_d[n], m_out[n], $time);
          break;
        end
      end
    end
  end

  task automatic rand_inputs(input bit small_vals);
    for (int n = 0; n < N; n++) begin
      b_d[n] = WW'($urandom);
      for (int k = 0; k < D; k++) w_d[n][k] = WW'($urandom);
    end
    for (int k = 0; k < D; k++)
      x_d[k] = small_vals ? DW'(int'($urandom_range(600)) - 300) : DW'($urandom);
    relu_d = 1'($urandom);
  endtask

  task automatic run_default(input int drop_at, input int hold_done, input bit scramble);
    int e;
    en_d = 1'b1;
    @(posedge clk);
    e = 0;
    @(negedge clk);
    while (term_d !== 1'b1 && e < 400) begin
      if (e == drop_at) en_d = 1'b0;
      if (scramble) x_d[$urandom_range(D-1)] = DW'($urandom);
      @(posedge clk); e++; @(negedge clk);
    end
    chk("latency_d", e, G * (D + 1));
    if (en_d) begin
      for (int i = 0; i < hold_done; i++) begin
        @(negedge clk);
        chk("hold_term_d", int'(term_d), 1);
        chk("hold_busy_d", int'(busy_d), 0);
      end
      en_d = 1'b0;
    end
    @(negedge clk);
    chk("term_drop_d", int'(term_d), 0);
  endtask

  task automatic set_row_s(input int n, input int a, input int b, input int c, input int bias);
    w_s[n][0] = WW'(a); w_s[n][1] = WW'(b); w_s[n][2] = WW'(c); b_s[n] = WW'(bias);
  endtask

  task automatic run_small(input bit relu, output int edges);
    relu_s = relu; en_s = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    en_s = 1'b0;
    chk("busy_s_start", int'(busy_s), 1);
    while (term_s !== 1'b1 && edges < 50) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("latency_s", edges, 8);
    @(negedge clk);
    chk("term_s_one_cycle", int'(term_s), 0);
  endtask

  int e;

  initial begin
    rst_n = 1'b0; en_d = 1'b0; relu_d = 1'b0; en_s = 1'b0; relu_s = 1'b0;
    rand_inputs(1'b1);
    for (int k = 0; k < SD; k++) x_s[k] = '0;
    for (int n = 0; n < SN; n++) set_row_s(n, 0, 0, 0, 0);

    chk("model_shift_floor", requant(-33, 4, 1'b0), -3);
    chk("model_sat_hi", requant(64'sd12484354, 0, 1'b1), 32767);
    chk("model_sat_lo", requant(-64'sd12484100, 0, 1'b0), -32768);
    chk("model_relu", requant(-6, 0, 1'b1), 0);
    chk("model_linear", requant(-6, 0, 1'b0), -6);

    repeat (3) @(negedge clk);
    chk("rst_busy_s", int'(busy_s), 0);
    chk("rst_term_s", int'(term_s), 0);
    for (int n = 0; n < SN; n++) chk("rst_out_s", int'(out_s[n]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // x={1,2,3}: dot products 6,-6,-1 and 0, biases 0,0,5,-2 -> acc {6,-6,4,-2}
    x_s[0] = 16'sd1; x_s[1] = 16'sd2; x_s[2] = 16'sd3;
    set_row_s(0, 1, 1, 1, 0);
    set_row_s(1, -1, -1, -1, 0);
    set_row_s(2, 2, 0, -1, 5);
    set_row_s(3, 0, 0, 0, -2);
    run_small(1'b1, e);
    chk("t1_o0", int'(out_s[0]), 6);  chk("t1_o1", int'(out_s[1]), 0);
    chk("t1_o2", int'(out_s[2]), 4);  chk("t1_o3", int'(out_s[3]), 0);
    for (int n = 0; n < SN; n++) chk("t1_h", int'(out_h[n]), 0);

    run_small(1'b0, e);
    chk("t2_o0", int'(out_s[0]), 6);  chk("t2_o1", int'(out_s[1]), -6);
    chk("t2_o2", int'(out_s[2]), 4);  chk("t2_o3", int'(out_s[3]), -2);
    chk("t2_h0", int'(out_h[0]), 0);  chk("t2_h1", int'(out_h[1]), -1);
    chk("t2_h2", int'(out_h[2]), 0);  chk("t2_h3", int'(out_h[3]), -1);

    for (int k = 0; k < SD; k++) x_s[k] = 16'sh7fff;
    set_row_s(0, 127, 127, 127, 127);
    run_small(1'b1, e);
    chk("t3_sat_hi", int'(out_s[0]), 32767);
    chk("t3_sat_hi_h", int'(out_h[0]), 32767);
    set_row_s(0, -127, -127, -127, 127);
    run_small(1'b0, e);
    chk("t3_sat_lo", int'(out_s[0]), -32768);
    chk("t3_sat_lo_h", int'(out_h[0]), -32768);

    x_s[0] = 16'sd1; x_s[1] = 16'sd0; x_s[2] = 16'sd0;
    set_row_s(0, -33, 0, 0, 0);
    run_small(1'b0, e);
    chk("t4_shift", int'(out_h[0]), -3);
    chk("t4_noshift", int'(out_s[0]), -33);

    rand_inputs(1'b1);
    run_default(10, 0, 1'b1);
    rand_inputs(1'b0);
    run_default(1000, 5, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rand_inputs(1'($urandom));
      run_default((r % 2 == 0) ? 1000 : int'($urandom_range(150)), int'($urandom_range(4)), 1'($urandom));
    end

    rand_inputs(1'b1);
    en_d = 1'b1;
    @(posedge clk);
    repeat (50) @(negedge clk);
    rst_n = 1'b0; en_d = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_d), 0);
    chk("abort_term", int'(term_d), 0);
    for (int n = 0; n < N; n++) chk("abort_out", int'(out_d[n]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    rand_inputs(1'b1);
    run_default(1000, 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
